// File: rtl/brick_wall_pkg.sv
// Shared Breakout geometry and state encoding for the brick wall, ball and renderer.
package brick_wall_pkg;

  localparam int ROWS     = 4;
  localparam int COLS     = 8;
  localparam int N        = ROWS * COLS;
  localparam int IDX_W    = $clog2(N);
  localparam int BRICK_W  = 64;
  localparam int BRICK_H  = 16;
  localparam int ORIGIN_X = 64;
  localparam int ORIGIN_Y = 48;
  localparam int R_BALL   = 8;

  localparam int GEOM_W   = 11;
  localparam int BW_SHIFT = $clog2(BRICK_W);
  localparam int BH_SHIFT = $clog2(BRICK_H);
  localparam int COL_SHIFT = $clog2(COLS);
  localparam int WALL_W   = COLS * BRICK_W;
  localparam int WALL_H   = ROWS * BRICK_H;

  localparam logic [9:0] RESET_X = 10'd320;
  localparam logic [9:0] RESET_Y = 10'd240;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  typedef struct packed {
    logic u;
    logic d;
    logic l;
    logic r;
  } hit_t;

endpackage

// File: rtl/brick_geom.sv
// Combinational bounding box (inclusive edges) of brick idx in 11-bit screen coordinates.
module brick_geom import brick_wall_pkg::*; (
  input  logic [IDX_W-1:0]  idx,
  output logic [GEOM_W-1:0] left,
  output logic [GEOM_W-1:0] right,
  output logic [GEOM_W-1:0] top,
  output logic [GEOM_W-1:0] bottom
);

  logic [GEOM_W-1:0] row;
  logic [GEOM_W-1:0] col;

  assign row    = GEOM_W'(idx) / GEOM_W'(COLS);
  assign col    = GEOM_W'(idx) % GEOM_W'(COLS);
  assign left   = GEOM_W'(ORIGIN_X) + col * GEOM_W'(BRICK_W);
  assign right  = left + GEOM_W'(BRICK_W - 1);
  assign top    = GEOM_W'(ORIGIN_Y) + row * GEOM_W'(BRICK_H);
  assign bottom = top + GEOM_W'(BRICK_H - 1);

endmodule

// File: rtl/brick_wall.sv
// Brick bitmap with a sequential collision scanner, held side-qualified hit,
// registered per-pixel brick mask, score and all-clear status.
module brick_wall import brick_wall_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic [9:0] x_ball,
  input  logic [9:0] y_ball,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  output logic       hit_block,
  output logic       hit_block_u,
  output logic       hit_block_d,
  output logic       hit_block_l,
  output logic       hit_block_r,
  output logic       area,
  output logic [5:0] score,
  output logic       all_clear
);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [9:0]        lx_reg, lx_next, ly_reg, ly_next;
  logic [N-1:0]      alive_reg, alive_next;
  logic [5:0]        score_reg, score_next;
  hit_t              hit_reg, hit_next;
  logic              all_clear_reg, area_reg, area_next;

  logic [GEOM_W-1:0] b_left, b_right, b_top, b_bottom;
  logic [GEOM_W-1:0] bx, by, rb, px, py;
  logic [IDX_W-1:0]  pix_idx;
  logic              moved, overlap;
  hit_t              scan_side;

  brick_geom u_geom (
    .idx    (idx_reg),
    .left   (b_left),
    .right  (b_right),
    .top    (b_top),
    .bottom (b_bottom)
  );

  assign moved   = (x_ball != lx_reg) || (y_ball != ly_reg);
  assign bx      = GEOM_W'(lx_reg);
  assign by      = GEOM_W'(ly_reg);
  assign rb      = GEOM_W'(R_BALL);
  assign overlap = (bx + rb >= b_left) && (bx <= b_right + rb) &&
                   (by + rb >= b_top)  && (by <= b_bottom + rb);

  always_comb begin
    scan_side = '0;
    if (by < b_top)         scan_side.u = 1'b1;
    else if (by > b_bottom) scan_side.d = 1'b1;
    else if (bx < b_left)   scan_side.l = 1'b1;
    else                    scan_side.r = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    lx_next    = lx_reg;
    ly_next    = ly_reg;
    alive_next = alive_reg;
    score_next = score_reg;
    hit_next   = hit_reg;
    if (restart) begin
      state_next = IDLE;
      idx_next   = '0;
      lx_next    = RESET_X;
      ly_next    = RESET_Y;
      alive_next = '1;
      score_next = '0;
      hit_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (moved) begin
            lx_next    = x_ball;
            ly_next    = y_ball;
            idx_next   = '0;
            state_next = SCAN;
          end
        end
        SCAN: begin
          // A move abandons the scan so the old position can never score.
          if (moved) begin
            lx_next  = x_ball;
            ly_next  = y_ball;
            idx_next = '0;
          end else if (alive_reg[idx_reg] && overlap) begin
            alive_next[idx_reg] = 1'b0;
            score_next = score_reg + 6'd1;
            hit_next   = scan_side;
            state_next = HOLD;
          end else if (idx_reg == IDX_W'(N - 1)) begin
            state_next = IDLE;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
        HOLD: begin
          if (moved) begin
            hit_next   = '0;
            lx_next    = x_ball;
            ly_next    = y_ball;
            idx_next   = '0;
            state_next = SCAN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign px      = GEOM_W'(next_x);
  assign py      = GEOM_W'(next_y);
  assign pix_idx = IDX_W'((((py - GEOM_W'(ORIGIN_Y)) >> BH_SHIFT) << COL_SHIFT) +
                          ((px - GEOM_W'(ORIGIN_X)) >> BW_SHIFT));
  assign area_next = (px >= GEOM_W'(ORIGIN_X)) && (px < GEOM_W'(ORIGIN_X + WALL_W)) &&
                     (py >= GEOM_W'(ORIGIN_Y)) && (py < GEOM_W'(ORIGIN_Y + WALL_H)) &&
                     alive_reg[pix_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      lx_reg        <= RESET_X;
      ly_reg        <= RESET_Y;
      alive_reg     <= '1;
      score_reg     <= '0;
      hit_reg       <= '0;
      all_clear_reg <= 1'b0;
      area_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      lx_reg        <= lx_next;
      ly_reg        <= ly_next;
      alive_reg     <= alive_next;
      score_reg     <= score_next;
      hit_reg       <= hit_next;
      all_clear_reg <= (alive_next == '0);
      area_reg      <= area_next;
    end
  end

  // The held hit is masked combinationally the moment the ball leaves the latched spot.
  assign hit_block   = (|hit_reg) & ~moved;
  assign hit_block_u = hit_reg.u & ~moved;
  assign hit_block_d = hit_reg.d & ~moved;
  assign hit_block_l = hit_reg.l & ~moved;
  assign hit_block_r = hit_reg.r & ~moved;
  assign area        = area_reg;
  assign score       = score_reg;
  assign all_clear   = all_clear_reg;

endmodule

// File: tb/tb_brick_wall.sv
// Scoreboard bench for brick_wall: a brick model predicts the struck brick, side and latency per move.
module tb_brick_wall;

  logic       clk = 1'b0;
  logic       rst_n, restart;
  logic [9:0] x_ball, y_ball, next_x, next_y;
  logic       hit_block, hit_block_u, hit_block_d, hit_block_l, hit_block_r;
  logic       area, all_clear;
  logic [5:0] score;

  always #5 clk = ~clk;

  brick_wall dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (restart),
    .x_ball      (x_ball),
    .y_ball      (y_ball),
    .next_x      (next_x),
    .next_y      (next_y),
    .hit_block   (hit_block),
    .hit_block_u (hit_block_u),
    .hit_block_d (hit_block_d),
    .hit_block_l (hit_block_l),
    .hit_block_r (hit_block_r),
    .area        (area),
    .score       (score),
    .all_clear   (all_clear)
  );

  typedef struct {
    int         k;
    logic [3:0] side;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  bit   alive_m[32];
  int   score_m;
  int   cyc;
  int   tests = 0;
  int   fails = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) alive_m[i] = 1'b1;
    score_m = 0;
  endfunction

  function automatic bit all_dead();
    for (int i = 0; i < 32; i++) if (alive_m[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_hit(input int x, input int y, output int k, output logic [3:0] side);
    k = -1;
    side = 4'b0000;
    for (int i = 0; i < 32; i++) begin
      int l, r, t, b;
      l = 64 + (i % 8) * 64;
      r = l + 63;
      t = 48 + (i / 8) * 16;
      b = t + 15;
      if (k < 0 && alive_m[i] && x + 8 >= l && x <= r + 8 && y + 8 >= t && y <= b + 8) begin
        k = i;
        if (y < t)      side = 4'b1000;
        else if (y > b) side = 4'b0100;
        else if (x < l) side = 4'b0010;
        else            side = 4'b0001;
      end
    end
  endfunction

  function automatic bit model_area(input int x, input int y);
    if (x < 64 || x >= 576 || y < 48 || y >= 112) return 1'b0;
    return alive_m[((y - 48) / 16) * 8 + (x - 64) / 64];
  endfunction

  // Each move supersedes any pending expectation from an abandoned position.
  task automatic set_ball(input int x, input int y);
    int k;
    logic [3:0] side;
    @(negedge clk);
    x_ball = 10'(x);
    y_ball = 10'(y);
    cyc = 0;
    model_hit(x, y, k, side);
    sb_q.delete();
    sb_q.push_back('{k, side, k + 2});
    $display("[TB] move to (%0d,%0d): expect brick %0d side %b latency %0d", x, y, k, side, k + 2);
  endtask

  task automatic wait_result();
    exp_t e;
    bit   seen;
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    seen = 1'b0;
    if (e.k < 0) begin
      repeat (36) begin
        @(negedge clk);
        if (hit_block === 1'b1) seen = 1'b1;
      end
      check_val("no_hit", 32'(seen), 0);
      check_val("no_side", {hit_block_u, hit_block_d, hit_block_l, hit_block_r}, 0);
    end else begin
      while (!seen && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (hit_block === 1'b1) seen = 1'b1;
      end
      check_val("hit_seen", 32'(seen), 1);
      if (seen) begin
        alive_m[e.k] = 1'b0;
        score_m++;
        check_val("hit_latency", cyc, e.lat);
        check_val("hit_side", {hit_block_u, hit_block_d, hit_block_l, hit_block_r}, e.side);
        check_val("score", score, score_m);
        check_val("all_clear", all_clear, 32'(all_dead()));
      end
    end
  endtask

  task automatic check_area(input int x, input int y);
    @(negedge clk);
    next_x = 10'(x);
    next_y = 10'(y);
    @(negedge clk);
    check_val("area", area, 32'(model_area(x, y)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    restart = 1'b0;
    x_ball  = 10'd320;
    y_ball  = 10'd240;
    next_x  = 10'd70;
    next_y  = 10'd50;
    model_reset();
    #12;
    check_val("reset_hit", hit_block, 0);
    check_val("reset_score", score, 0);
    check_val("reset_all_clear", all_clear, 0);
    check_val("reset_area", area, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("idle_hit", hit_block, 0);
    check_area(70, 50);
    check_val("idle_score", score, 0);
    check_val("idle_all_clear", all_clear, 0);

    set_ball(96, 70);
    wait_result();
    check_area(70, 50);
    set_ball(96, 88);
    wait_result();
    set_ball(60, 100);
    wait_result();
    repeat (5) @(negedge clk);
    check_val("hold_hit", hit_block, 1);
    check_val("hold_left", hit_block_l, 1);
    set_ball(62, 100);
    #1;
    check_val("drop_on_move", hit_block, 0);
    wait_result();

    set_ball(544, 104);
    repeat (5) @(negedge clk);
    check_val("midscan_quiet", hit_block, 0);
    set_ball(160, 56);
    wait_result();
    check_area(540, 100);

    set_ball(544, 104);
    repeat (5) @(negedge clk);
    check_val("pre_reset_area", area, 32'(model_area(540, 100)));
    #2;
    rst_n  = 1'b0;
    x_ball = 10'd320;
    y_ball = 10'd240;
    #1;
    check_val("async_hit", hit_block, 0);
    check_val("async_score", score, 0);
    check_val("async_all_clear", all_clear, 0);
    check_val("async_area", area, 0);
    model_reset();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("post_reset_hit", hit_block, 0);
    check_area(70, 50);
    check_val("post_reset_score", score, 0);

    for (int k = 0; k < 32; k++) begin
      set_ball(96 + (k % 8) * 64, 56 + (k / 8) * 16);
      wait_result();
    end
    check_val("final_score", score, 32);
    check_val("final_all_clear", all_clear, 1);
    set_ball(320, 240);
    wait_result();

    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_reset();
    check_val("restart_score", score, 0);
    check_val("restart_all_clear", all_clear, 0);
    check_area(70, 50);

    set_ball(96, 70);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    x_ball  = 10'd320;
    y_ball  = 10'd240;
    sb_q.delete();
    check_val("coinc_score", score, 0);
    check_val("coinc_hit", hit_block, 0);
    repeat (4) @(negedge clk);
    check_val("coinc_score_late", score, 0);
    check_val("coinc_hit_late", hit_block, 0);
    check_area(70, 50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
